// File: rtl/jk_seq_pkg.sv
// Shared codes for the JK bank sequencer: command modes, FSM states and
// the {J,K} pair encodings understood by jk_cell.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_SHIFT  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // {J,K} pairs
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_seq_ctrl_cell.sv
// Single JK flip-flop with synchronous active-high reset and complementary
// outputs; the primitive the sequencer drives.
module jk_cell
  import jk_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_SET:  q <= 1'b1;
        JK_CLR:  q <= 1'b0;
        JK_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qn = ~q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer for a bank of N JK cells: latches mode/length on start,
// then steps the bank for that many cycles and pulses done.
//
// state  | meaning
// S_IDLE | bank holds; waiting for start_i
// S_RUN  | one step per edge until the step counter reaches its last step
// S_DONE | one-cycle completion pulse; start_i ignored
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             sin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [N-1:0]     q_o
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     q_w, qn_w;
  logic [N-1:0]     step_j, step_k;
  logic [N-1:0]     cell_j, cell_k;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_UP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    cell_j  = '0;
    cell_k  = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d  = mode_e'(mode_i);
          cnt_d   = len_i;
          state_d = (len_i != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        cell_j = step_j;
        cell_k = step_k;
        cnt_d  = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ripple-carry style enables: a cell toggles when every lower cell is 1 (up) or 0 (down).
  always_comb begin
    logic up_c;
    logic dn_c;
    up_c   = 1'b1;
    dn_c   = 1'b1;
    step_j = '0;
    step_k = '0;
    for (int i = 0; i < N; i++) begin
      case (mode_q)
        MODE_UP: begin
          step_j[i] = up_c;
          step_k[i] = up_c;
        end
        MODE_DOWN: begin
          step_j[i] = dn_c;
          step_k[i] = dn_c;
        end
        MODE_SHIFT: begin
          step_j[i] = (i == 0) ? sin_i : q_w[(i == 0) ? 0 : i-1];
          step_k[i] = ~step_j[i];
        end
        default: begin
          step_j[i] = 1'b1;
          step_k[i] = 1'b1;
        end
      endcase
      up_c = up_c & q_w[i];
      dn_c = dn_c & qn_w[i];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cell
    jk_cell u_cell (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .j     (cell_j[g]),
      .k     (cell_k[g]),
      .q     (q_w[g]),
      .qn    (qn_w[g])
    );
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);
  assign q_o    = q_w;

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed bench for jk_seq_ctrl (N=4): expected bank values are queued at
// command issue and compared when the done pulse appears.
module tb_jk_seq_ctrl;

  localparam int N     = 4;
  localparam int LEN_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [1:0]       mode_i;
  logic [LEN_W-1:0] len_i;
  logic             sin_i;
  logic             busy_o;
  logic             done_o;
  logic [N-1:0]     q_o;

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] mq;
  logic [N-1:0] exp_q[$];

  jk_seq_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .len_i   (len_i),
    .sin_i   (sin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .q_o     (q_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [N-1:0] model_step(input logic [1:0] m, input logic [N-1:0] q,
                                               input logic s);
    case (m)
      2'b00:   return q + 1'b1;
      2'b01:   return q - 1'b1;
      2'b10:   return {q[N-2:0], s};
      default: return ~q;
    endcase
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    start_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
    mq = '0;
    chk("reset_q", q_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
  endtask

  // Issue one command; optionally pulse start (with other mode/len) during RUN and DONE.
  task automatic cmd(input string tag, input logic [1:0] m, input int len,
                     input logic [15:0] sinv, input bit noise);
    int c;
    int nbusy;
    logic [N-1:0] e;
    e = mq;
    for (int i = 0; i < len; i++) e = model_step(m, e, sinv[i]);
    exp_q.push_back(e);
    mq = e;
    start_i = 1'b1;
    mode_i  = m;
    len_i   = LEN_W'(len);
    tick();
    start_i = 1'b0;
    c = 0;
    nbusy = 0;
    while (!done_o && c < len + 4) begin
      if (busy_o) begin
        sin_i = sinv[nbusy];
        nbusy++;
        if (noise && nbusy == 2) begin
          start_i = 1'b1;
          mode_i  = ~m;
          len_i   = 8'd7;
        end else begin
          start_i = 1'b0;
          mode_i  = ~m;
        end
      end
      tick();
      c++;
    end
    start_i = 1'b0;
    chk({tag, "_done_latency"}, c, len);
    chk({tag, "_busy_cycles"}, nbusy, len);
    chk({tag, "_q"}, q_o, exp_q.pop_front());
    if (noise) begin
      start_i = 1'b1;
      len_i   = 8'd3;
    end
    tick();
    start_i = 1'b0;
    chk({tag, "_done_one_cycle"}, done_o, 0);
    chk({tag, "_idle_busy"}, busy_o, 0);
    tick();
    chk({tag, "_idle_hold_q"}, q_o, mq);
    chk({tag, "_idle_stays"}, busy_o | done_o, 0);
  endtask

  initial begin
    int seen_done;
    rst_i = 1'b1; start_i = 1'b0; mode_i = 2'b00; len_i = '0; sin_i = 1'b0;
    mq = '0;
    do_reset();

    cmd("up5", 2'b00, 5, 16'h0, 1'b0);
    do_reset();
    cmd("up14", 2'b00, 14, 16'h0, 1'b0);
    cmd("up3_wrap", 2'b00, 3, 16'h0, 1'b0);
    cmd("down1", 2'b01, 1, 16'h0, 1'b0);
    cmd("down1_wrap", 2'b01, 1, 16'h0, 1'b0);
    cmd("tgl1", 2'b11, 1, 16'h0, 1'b0);
    cmd("tgl2", 2'b11, 2, 16'h0, 1'b0);
    // sin sequence 1,0,1,1 -> 4'b1011
    cmd("shift4", 2'b10, 4, 16'b1101, 1'b0);
    cmd("len0", 2'b00, 0, 16'h0, 1'b0);
    cmd("up4_noise", 2'b00, 4, 16'h0, 1'b1);
    cmd("down6", 2'b01, 6, 16'h0, 1'b0);

    // Reset in the third RUN cycle of UP len=10.
    start_i = 1'b1; mode_i = 2'b00; len_i = 8'd10;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    chk("rst_mid_q_before", q_o, mq + 4'd2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    mq = '0;
    chk("rst_mid_q", q_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_done", done_o, 0);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o || busy_o) seen_done++;
      tick();
    end
    chk("rst_mid_no_done", seen_done, 0);
    cmd("up3_after_rst", 2'b00, 3, 16'h0, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
